cpu_tlb_walker: RTL

Hardware page-table walker: the refill (writer) side of the CPU TLB. On a TLB miss it accepts the missing key, performs a two-level page-table read over a valid/ready memory port, then writes the translation into the TLB through the TLB's key/value/write port. It also returns the result, or a fault, to the requesting pipeline stage. Only one walk is in flight at a time.

---
 rtl/cpu_tlb_walker_pkg.sv | 16 +
 rtl/cpu_pte_decode.sv | 22 ++
 rtl/cpu_tlb_walker.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_tlb_walker_pkg.sv
// Shared definitions for the TLB refill walker: FSM state encoding and PTE field layout.
package cpu_tlb_walker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_L1_REQ  = 3'd1;
  localparam state_t S_L1_WAIT = 3'd2;
  localparam state_t S_L2_REQ  = 3'd3;
  localparam state_t S_L2_WAIT = 3'd4;
  localparam state_t S_FILL    = 3'd5;
  localparam state_t S_FAULT   = 3'd6;

  localparam int PTE_VALID_BIT = 0;

endpackage

// File: rtl/cpu_pte_decode.sv
// Combinational PTE field extraction, shared by both levels of the walk.
module cpu_pte_decode
  import cpu_tlb_walker_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int VALUE_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]  pte,
  output logic                   valid,
  output logic [ADDR_WIDTH-1:0]  base,
  output logic [VALUE_WIDTH-1:0] value
);

  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(3);

  assign valid = pte[PTE_VALID_BIT];
  // Next-level table base is word aligned: the low two bits are flag space.
  assign base  = pte[ADDR_WIDTH-1:0] & BASE_MASK;
  assign value = pte[DATA_WIDTH-1 -: VALUE_WIDTH];

endmodule

// File: rtl/cpu_tlb_walker.sv
// Two-level hardware page-table walker that refills the CPU TLB on a miss
// and reports the translation or a fault back to the requesting stage.
module cpu_tlb_walker
  import cpu_tlb_walker_pkg::*;
#(
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  ptbr,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [KEY_WIDTH-1:0]   req_key,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_resp_data,
  output logic                   tlb_write,
  output logic [KEY_WIDTH-1:0]   tlb_key,
  output logic [VALUE_WIDTH-1:0] tlb_value,
  output logic                   resp_valid,
  output logic                   resp_fault,
  output logic [VALUE_WIDTH-1:0] resp_value
);

  localparam int HALF = KEY_WIDTH / 2;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 state, state_nxt;
  logic [KEY_WIDTH-1:0]   key_reg;
  logic [ADDR_WIDTH-1:0]  ptbr_reg;
  logic [ADDR_WIDTH-1:0]  l2_base_reg;
  logic [VALUE_WIDTH-1:0] value_reg;
  logic [CW-1:0]          to_cnt;

  logic                   pte_valid;
  logic [ADDR_WIDTH-1:0]  pte_base;
  logic [VALUE_WIDTH-1:0] pte_value;
  logic                   timed_out;
  logic [ADDR_WIDTH-1:0]  l1_addr, l2_addr;

  cpu_pte_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_pte_decode (
    .pte   (mem_resp_data),
    .valid (pte_valid),
    .base  (pte_base),
    .value (pte_value)
  );

  // Expiry fires on the TIMEOUT-th silent wait cycle; a response that cycle still wins.
  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign l1_addr   = ptbr_reg + ADDR_WIDTH'({key_reg[KEY_WIDTH-1:HALF], 2'b00});
  assign l2_addr   = l2_base_reg + ADDR_WIDTH'({key_reg[HALF-1:0], 2'b00});

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (req_valid) state_nxt = S_L1_REQ;
      S_L1_REQ:  if (mem_req_ready) state_nxt = S_L1_WAIT;
      S_L1_WAIT: begin
        if (mem_resp_valid) state_nxt = pte_valid ? S_L2_REQ : S_FAULT;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_L2_REQ:  if (mem_req_ready) state_nxt = S_L2_WAIT;
      S_L2_WAIT: begin
        if (mem_resp_valid) state_nxt = pte_valid ? S_FILL : S_FAULT;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_FILL, S_FAULT: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      key_reg     <= '0;
      ptbr_reg    <= '0;
      l2_base_reg <= '0;
      value_reg   <= '0;
      to_cnt      <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            key_reg  <= req_key;
            ptbr_reg <= ptbr;
          end
        end
        S_L1_REQ, S_L2_REQ: if (mem_req_ready) to_cnt <= '0;
        S_L1_WAIT: begin
          if (mem_resp_valid && pte_valid) l2_base_reg <= pte_base;
          else if (!mem_resp_valid)        to_cnt <= to_cnt + 1'b1;
        end
        S_L2_WAIT: begin
          if (mem_resp_valid && pte_valid) value_reg <= pte_value;
          else if (!mem_resp_valid)        to_cnt <= to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign mem_req_valid = (state == S_L1_REQ) || (state == S_L2_REQ);
  assign mem_addr      = (state == S_L1_REQ) ? l1_addr :
                         (state == S_L2_REQ) ? l2_addr : '0;
  assign tlb_write     = (state == S_FILL);
  assign tlb_key       = key_reg;
  assign tlb_value     = value_reg;
  assign resp_valid    = (state == S_FILL) || (state == S_FAULT);
  assign resp_fault    = (state == S_FAULT);
  assign resp_value    = value_reg;

endmodule
